error_capture: RTL and testbench
================================

Name: error_capture

Overview:
- Upstream stage of the error status/display block.
- Conditions four raw error lines taken from pushbuttons or fault sources: synchronises them, debounces them, and latches each as a sticky error.
- Produces the 4-bit error vector and the status flag that the display/LED stage consumes.
- Adds a clear handshake, a fault event counter, and first-fault identification.

Parameters:
- DEBOUNCE_CYCLES, 5, consecutive stable synced cycles required before a debounced level changes (50 ms at 100 Hz); legal range 1..255.
- CNT_W, 8, width of the saturating fault counter.

Ports:
- hz100  input  1  system clock (100 Hz).
- reset  input  1  asynchronous, active-low reset; all flops clear while low.
- err_in  input  4  raw error lines; bit 3 = high priority, bit 2 = low priority, bits 1:0 = low.
- clear  input  1  operator clear request, level, asynchronous to logic (synchronised internally).
- error  output  4  sticky latched error vector, to the status/display stage.
- status  output  1  registered fault flag; 1 exactly when the FSM is in FAULT.
- fault_cnt  output  CNT_W  number of RUN->FAULT entries, saturating.
- first_err  output  2  index of the highest-priority sticky bit at FAULT entry.
- first_valid  output  1  first_err holds a captured value.

Behaviour:
- Reset (reset low, asynchronous): synchronisers=0, debounced=0, counters=0, error=0, status=0, fault_cnt=0, first_err=0, first_valid=0, state=RUN.
- Input conditioning:
  - Each err_in bit and clear passes through a 2-flop synchroniser.
  - Per-bit debounce counter increments while the synced value differs from the debounced value, and resets to 0 when they match.
  - The debounced value toggles, and the counter resets, on the cycle the counter reaches DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES cycles has no effect.
- Qualifying function: qual = (|error[1:0] & error[2]) | error[3]. This is the same equation the downstream stage uses.
- FSM states RUN, FAULT, CLEAR_WAIT:
  - Sticky latching happens in RUN and FAULT: error[i] <= error[i] | deb[i] each cycle. Latching is level-based. Bits never self-clear.
  - RUN -> FAULT when qual (evaluated on registered error) is 1.
    - On that transition: fault_cnt += 1, saturating at 2^CNT_W-1.
    - first_err <= index of the highest set error bit (3 > 2 > 1 > 0).
    - first_valid <= 1.
  - RUN or FAULT -> CLEAR_WAIT when synced clear is 1.
    - Clear has priority over a simultaneous FAULT entry; no count increment that cycle.
  - CLEAR_WAIT: error forced to 0, no latching, first_valid <= 0, fault_cnt retained. -> RUN when synced clear is 0.
  - On the cycle after exit, any still-high debounced input re-latches. A held fault therefore re-enters FAULT and increments the count again.
- Non-qualifying bits (for example, only bit 0, or only bit 2) latch into error but keep the FSM in RUN. They later qualify if a partner bit arrives.
- Latency: err_in held stable from before edge 0 gives debounced high at edge DEBOUNCE_CYCLES+1, error at edge DEBOUNCE_CYCLES+2, and status at edge DEBOUNCE_CYCLES+3 (edge 8 for the default).
- Clear latency: 2 sync cycles + 1 to CLEAR_WAIT. status falls on the 3rd edge after clear rises. Clear is not debounced.
- Reset mid-debounce or mid-fault discards all progress. No output glitches on reset deassertion.

Decomposition:
- Shared package error_pkg:
  - state enum error_state_t {RUN, FAULT, CLEAR_WAIT}.
  - Bit-index constants ERR_HI=3, ERR_LO=2.
  - Function err_qualify(logic [3:0]), used here and in the display stage so both use one equation.
- Sub-module debounce_bit (synchroniser + counter, parameter DEBOUNCE_CYCLES), instantiated 4 times.

Test Plan:
- Reset, then err_in=4'b1000 held -> status=1 at edge 8; error=4'b1000, fault_cnt=1, first_err=3, first_valid=1.
- err_in=4'b0100 pulse lasting 3 cycles -> error stays 0 and status stays 0 (glitch rejected).
- err_in=4'b0101 held -> status=1, first_err=2. Release inputs -> error stays 4'b0101 and status stays 1 (sticky).
- In FAULT with inputs low, clear high 4 cycles then low -> status=0 at 3rd edge, error=0, first_valid=0, fault_cnt unchanged. Repeat with err_in=4'b1000 still held -> re-enters FAULT and fault_cnt increments by 1.
- err_in=4'b0011 only -> error=4'b0011, status stays 0. Add bit 2 -> status=1.
- Force fault_cnt to 255 via repeated fault/clear cycles, then one more fault -> fault_cnt stays 255. Assert reset mid-debounce -> all outputs 0 immediately.

Source files
------------

// File: rtl/error_pkg.sv
// Shared types and the fault-qualify equation for the error path.
// Both capture and display stages import this so they agree on one rule.
package error_pkg;

  typedef enum logic [1:0] {
    RUN,
    FAULT,
    CLEAR_WAIT
  } error_state_t;

  localparam int ERR_HI = 3;
  localparam int ERR_LO = 2;

  function automatic logic err_qualify(
    input logic [3:0] e
  );
    return ((|e[1:0]) & e[ERR_LO])
         | e[ERR_HI];
  endfunction

  function automatic logic [1:0] err_first(
    input logic [3:0] e
  );
    logic [1:0] idx;
    idx = 2'd0;
    if (e[3])      idx = 2'd3;
    else if (e[2]) idx = 2'd2;
    else if (e[1]) idx = 2'd1;
    return idx;
  endfunction

endpackage

// File: rtl/error_capture_if.sv
// Raw error/clear inputs and latched status outputs of error_capture.
// The master side drives the raw lines, the slave side is the capture block.
interface error_capture_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       err_in;
  logic             clear;
  logic [3:0]       error;
  logic             status;
  logic [CNT_W-1:0] fault_cnt;
  logic [1:0]       first_err;
  logic             first_valid;

  modport master (
    output err_in, clear,
    input  error, status, fault_cnt,
    input  first_err, first_valid
  );

  modport slave (
    input  err_in, clear,
    output error, status, fault_cnt,
    output first_err, first_valid
  );
endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      q   <= 1'b0;
      cnt <= 8'd0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s2 == q) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        q   <= ~q;
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/error_capture.sv
// Conditions four raw error lines into a sticky error vector and fault FSM.
// Also counts fault entries and records which bit triggered the fault.
module error_capture
  import error_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int CNT_W           = 8
) (
  input  logic          hz100,
  input  logic          reset,
  error_capture_if.slave bus
);

  logic [3:0]       deb;
  logic             clr_s1;
  logic             clr_s;
  logic [3:0]       err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       first_q;
  logic             fvalid_q;
  error_state_t     state_q;
  error_state_t     state_d;
  logic             latch;
  logic             enter;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (hz100),
      .rst_n(reset),
      .d    (bus.err_in[i]),
      .q    (deb[i])
    );
  end

  // Clear is a plain level: synchronised but deliberately not debounced.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      clr_s1 <= 1'b0;
      clr_s  <= 1'b0;
    end else begin
      clr_s1 <= bus.clear;
      clr_s  <= clr_s1;
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    enter   = 1'b0;
    unique case (state_q)
      RUN: begin
        latch = 1'b1;
        if (clr_s) begin
          state_d = CLEAR_WAIT;
        end else if (err_qualify(err_q)) begin
          state_d = FAULT;
          enter   = 1'b1;
        end
      end
      FAULT: begin
        latch = 1'b1;
        if (clr_s) state_d = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        if (!clr_s) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Error and first_valid read as zero for the whole CLEAR_WAIT stay.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      err_q    <= 4'd0;
      cnt_q    <= '0;
      first_q  <= 2'd0;
      fvalid_q <= 1'b0;
    end else begin
      if (state_d == CLEAR_WAIT) begin
        err_q    <= 4'd0;
        fvalid_q <= 1'b0;
      end else if (latch) begin
        err_q <= err_q | deb;
      end
      if (enter) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        first_q  <= err_first(err_q);
        fvalid_q <= 1'b1;
      end
    end
  end

  assign bus.error       = err_q;
  assign bus.status      = (state_q == FAULT);
  assign bus.fault_cnt   = cnt_q;
  assign bus.first_err   = first_q;
  assign bus.first_valid = fvalid_q;

endmodule

// File: tb/tb_error_capture.sv
// Directed bench for error_capture: latency, glitch, sticky, clear,
// partner qualification, counter saturation and async reset.
module tb_error_capture;

  logic hz100;
  logic reset;
  int   n_tests;
  int   n_fail;

  error_capture_if #(.CNT_W(8)) bus ();

  error_capture #(
    .DEBOUNCE_CYCLES(5),
    .CNT_W          (8)
  ) dut (
    .hz100(hz100),
    .reset(reset),
    .bus  (bus)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic clear_pulse();
    bus.clear = 1'b1;
    step(4);
    bus.clear = 1'b0;
    step(6);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_err"}, 32'(bus.error), 0);
    chk({tag, "_st"},  32'(bus.status), 0);
    chk({tag, "_cnt"}, 32'(bus.fault_cnt), 0);
    chk({tag, "_fe"},  32'(bus.first_err), 0);
    chk({tag, "_fv"},  32'(bus.first_valid), 0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    bus.err_in = 4'd0;
    bus.clear  = 1'b0;
    step(2);
    chk_zero("rst");
    reset = 1'b1;
    step(1);

    // high-priority bit: status exactly at edge 8
    bus.err_in = 4'b1000;
    step(8);
    chk("hi_pre_st", 32'(bus.status), 0);
    chk("hi_pre_err", 32'(bus.error), 4'b1000);
    step(1);
    chk("hi_st",  32'(bus.status), 1);
    chk("hi_err", 32'(bus.error), 4'b1000);
    chk("hi_cnt", 32'(bus.fault_cnt), 1);
    chk("hi_fe",  32'(bus.first_err), 3);
    chk("hi_fv",  32'(bus.first_valid), 1);

    // clear with inputs low: status falls on 3rd edge
    bus.err_in = 4'd0;
    step(10);
    bus.clear = 1'b1;
    step(2);
    chk("clr_e2_st", 32'(bus.status), 1);
    step(1);
    chk("clr_st",  32'(bus.status), 0);
    chk("clr_err", 32'(bus.error), 0);
    chk("clr_fv",  32'(bus.first_valid), 0);
    chk("clr_cnt", 32'(bus.fault_cnt), 1);
    step(1);
    bus.clear = 1'b0;
    step(6);
    chk("run_st",  32'(bus.status), 0);
    chk("run_err", 32'(bus.error), 0);

    // 3-cycle glitch is rejected
    bus.err_in = 4'b0100;
    step(3);
    bus.err_in = 4'd0;
    step(12);
    chk("gl_err", 32'(bus.error), 0);
    chk("gl_st",  32'(bus.status), 0);

    // low-priority pair qualifies and sticks
    bus.err_in = 4'b0101;
    step(9);
    chk("lo_st",  32'(bus.status), 1);
    chk("lo_fe",  32'(bus.first_err), 2);
    chk("lo_cnt", 32'(bus.fault_cnt), 2);
    bus.err_in = 4'd0;
    step(10);
    chk("sticky_err", 32'(bus.error), 4'b0101);
    chk("sticky_st",  32'(bus.status), 1);
    clear_pulse();
    chk("lo_clr_st", 32'(bus.status), 0);
    chk("lo_clr_cnt", 32'(bus.fault_cnt), 2);

    // held fault re-enters after clear
    bus.err_in = 4'b1000;
    step(10);
    chk("hold_st",  32'(bus.status), 1);
    chk("hold_cnt", 32'(bus.fault_cnt), 3);
    clear_pulse();
    chk("re_st",  32'(bus.status), 1);
    chk("re_cnt", 32'(bus.fault_cnt), 4);
    chk("re_fv",  32'(bus.first_valid), 1);
    bus.err_in = 4'd0;
    step(10);
    clear_pulse();

    // non-qualifying bits latch, partner makes them qualify
    bus.err_in = 4'b0011;
    step(10);
    chk("nq_err", 32'(bus.error), 4'b0011);
    chk("nq_st",  32'(bus.status), 0);
    bus.err_in = 4'b0111;
    step(10);
    chk("pq_st",  32'(bus.status), 1);
    chk("pq_fe",  32'(bus.first_err), 2);
    chk("pq_cnt", 32'(bus.fault_cnt), 5);
    bus.err_in = 4'd0;
    step(10);
    clear_pulse();

    // saturate the fault counter
    bus.err_in = 4'b1000;
    step(10);
    chk("sat6_cnt", 32'(bus.fault_cnt), 6);
    for (int i = 0; i < 249; i++) clear_pulse();
    chk("sat_cnt", 32'(bus.fault_cnt), 255);
    clear_pulse();
    chk("sat_hold", 32'(bus.fault_cnt), 255);
    chk("sat_st",   32'(bus.status), 1);

    // async reset mid-debounce and mid-fault
    bus.err_in = 4'b0101;
    step(3);
    #2 reset = 1'b0;
    #1 chk_zero("arst");
    step(1);
    reset = 1'b1;
    bus.err_in = 4'd0;
    step(10);
    chk("post_err", 32'(bus.error), 0);
    chk("post_cnt", 32'(bus.fault_cnt), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
